// File: rtl/wb_write_arbiter_if.sv
// Signal bundle for the register-file write arbiter: ALU and long-latency result inputs,
// the decode scoreboard query, and the write port that goes to the register file.
interface wb_write_arbiter_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            stall;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_valid, issue_rd, rs1, rs2,
    input  lsu_ready, stall, rf_we, rf_rd, rf_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_valid, issue_rd, rs1, rs2,
    output lsu_ready, stall, rf_we, rf_rd, rf_data
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write arbiter: ALU results win the port, and long-latency results drain
// in order from a small FIFO. A pending scoreboard stalls decode on outstanding destinations.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic               clk,
  input logic               rst,
  wb_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t        fifo [DEPTH];
  entry_t        head_entry;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic [31:0]   pending;
  logic [31:0]   pending_next;
  logic          alu_take;
  logic          push;
  logic          pop;
  logic          issue_set;

  assign head_entry    = fifo[head];
  assign alu_take      = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign pop           = !alu_take && (count != '0);
  assign bus.lsu_ready = !rst && (count < CAP);
  assign push          = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != 5'd0);
  assign issue_set     = bus.issue_valid && (bus.issue_rd != 5'd0) && !bus.stall;

  // Last term holds a second long-latency op to a register still in flight (WAW).
  assign bus.stall = ((bus.rs1 != 5'd0) && pending[bus.rs1]) ||
                     ((bus.rs2 != 5'd0) && pending[bus.rs2]) ||
                     (bus.issue_valid && (bus.issue_rd != 5'd0) && pending[bus.issue_rd]);

  // A new issue to the register being popped must stay pending, so set is applied last.
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[head_entry.rd] = 1'b0;
    if (issue_set) pending_next[bus.issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[tail] <= '{rd: bus.lsu_rd, data: bus.lsu_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rf_we   <= 1'b0;
      bus.rf_rd   <= 5'd0;
      bus.rf_data <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      pending     <= '0;
    end else begin
      if (alu_take) begin
        bus.rf_we   <= 1'b1;
        bus.rf_rd   <= bus.alu_rd;
        bus.rf_data <= bus.alu_data;
      end else if (pop) begin
        bus.rf_we   <= 1'b1;
        bus.rf_rd   <= head_entry.rd;
        bus.rf_data <= head_entry.data;
      end else begin
        bus.rf_we   <= 1'b0;
      end
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      pending <= pending_next;
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed vector table and reset sequence with constant
// expectations, then randomized traffic against a queue-based reference model.
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_write_arbiter_if #(.XLEN(XLEN)) bus ();

  wb_write_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic            rst;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            exp_ready;
    logic            exp_stall;
    logic            exp_we;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  vec_t table_q[$];

  // Reference model: in-order queue of results plus a per-register pending flag.
  ent_t            q[$];
  bit              pend [32];
  logic            m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;

  function automatic vec_t mk(int r, int av, int ard, logic [31:0] ad, int lv, int lrd,
                              logic [31:0] ld, int iv, int ird, int s1, int s2,
                              int er, int es, int ew, int erd, logic [31:0] ed);
    vec_t v;
    v.rst = 1'(r);          v.alu_valid = 1'(av);    v.alu_rd = 5'(ard);  v.alu_data = ad;
    v.lsu_valid = 1'(lv);   v.lsu_rd = 5'(lrd);      v.lsu_data = ld;
    v.issue_valid = 1'(iv); v.issue_rd = 5'(ird);    v.rs1 = 5'(s1);      v.rs2 = 5'(s2);
    v.exp_ready = 1'(er);   v.exp_stall = 1'(es);    v.exp_we = 1'(ew);
    v.exp_rd = 5'(erd);     v.exp_data = ed;
    return v;
  endfunction

  function automatic bit model_stall(vec_t v);
    return (v.rs1 != 0 && pend[v.rs1]) || (v.rs2 != 0 && pend[v.rs2]) ||
           (v.issue_valid && v.issue_rd != 0 && pend[v.issue_rd]);
  endfunction

  task automatic model_step(vec_t v, bit stall_now);
    ent_t e;
    bit room;
    if (v.rst) begin
      q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      m_we = 1'b0; m_rd = '0; m_data = '0;
    end else begin
      room = q.size() < DEPTH;
      if (v.alu_valid && v.alu_rd != 0) begin
        m_we = 1'b1; m_rd = v.alu_rd; m_data = v.alu_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_we = 1'b1; m_rd = e.rd; m_data = e.data;
        pend[e.rd] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (v.lsu_valid && room && v.lsu_rd != 0) begin
        e.rd = v.lsu_rd; e.data = v.lsu_data;
        q.push_back(e);
      end
      if (v.issue_valid && v.issue_rd != 0 && !stall_now) pend[v.issue_rd] = 1'b1;
    end
  endtask

  task automatic apply_stimulus(vec_t v);
    rst             = v.rst;
    bus.alu_valid   = v.alu_valid;
    bus.alu_rd      = v.alu_rd;
    bus.alu_data    = v.alu_data;
    bus.lsu_valid   = v.lsu_valid;
    bus.lsu_rd      = v.lsu_rd;
    bus.lsu_data    = v.lsu_data;
    bus.issue_valid = v.issue_valid;
    bus.issue_rd    = v.issue_rd;
    bus.rs1         = v.rs1;
    bus.rs2         = v.rs2;
  endtask

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  // Drive at negedge, check combinational outputs mid-cycle, registered ones just after posedge.
  task automatic run_cycle(vec_t v, bit use_model);
    bit exp_ready;
    bit exp_stall;
    @(negedge clk);
    apply_stimulus(v);
    #1;
    exp_ready = use_model ? (!v.rst && q.size() < DEPTH) : v.exp_ready;
    exp_stall = use_model ? model_stall(v) : v.exp_stall;
    check_output("lsu_ready", 32'(bus.lsu_ready), 32'(exp_ready));
    check_output("stall", 32'(bus.stall), 32'(exp_stall));
    @(posedge clk);
    model_step(v, model_stall(v));
    #1;
    check_output("rf_we", 32'(bus.rf_we), 32'(use_model ? m_we : v.exp_we));
    check_output("rf_rd", 32'(bus.rf_rd), 32'(use_model ? m_rd : v.exp_rd));
    check_output("rf_data", 32'(bus.rf_data), 32'(use_model ? m_data : v.exp_data));
    cycle++;
  endtask

  initial begin
    vec_t v;
    apply_stimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    m_we = 1'b0; m_rd = '0; m_data = '0;
    foreach (pend[i]) pend[i] = 1'b0;

    //                 r av ard  adata   lv lrd ldata    iv ird s1 s2  rdy stl we  rd  data
    table_q.push_back(mk(1, 0, 0, 0,      0, 0, 0,       0, 0,  0, 0,  0, 0, 0, 0,  0));
    table_q.push_back(mk(1, 0, 0, 0,      0, 0, 0,       0, 0,  0, 0,  0, 0, 0, 0,  0));
    table_q.push_back(mk(0, 1, 5, 'hAA,   0, 0, 0,       0, 0,  0, 0,  1, 0, 1, 5,  'hAA));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  0, 0,  1, 0, 0, 5,  'hAA));
    table_q.push_back(mk(0, 0, 0, 0,      1, 7, 'h1234,  0, 0,  0, 0,  1, 0, 0, 5,  'hAA));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  0, 0,  1, 0, 1, 7,  'h1234));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  0, 0,  1, 0, 0, 7,  'h1234));
    table_q.push_back(mk(0, 1, 3, 'h33,   1, 8, 'h80,    0, 0,  0, 0,  1, 0, 1, 3,  'h33));
    table_q.push_back(mk(0, 1, 3, 'h34,   1, 9, 'h90,    0, 0,  0, 0,  1, 0, 1, 3,  'h34));
    table_q.push_back(mk(0, 1, 3, 'h35,   1, 10, 'hA0,   0, 0,  0, 0,  1, 0, 1, 3,  'h35));
    table_q.push_back(mk(0, 1, 3, 'h36,   1, 11, 'hB0,   0, 0,  0, 0,  1, 0, 1, 3,  'h36));
    table_q.push_back(mk(0, 1, 3, 'h37,   1, 12, 'hC0,   0, 0,  0, 0,  0, 0, 1, 3,  'h37));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  0, 0,  0, 0, 1, 8,  'h80));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  0, 0,  1, 0, 1, 9,  'h90));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  0, 0,  1, 0, 1, 10, 'hA0));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  0, 0,  1, 0, 1, 11, 'hB0));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  0, 0,  1, 0, 0, 11, 'hB0));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       1, 6,  0, 0,  1, 0, 0, 11, 'hB0));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  6, 0,  1, 1, 0, 11, 'hB0));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  0, 0,  1, 0, 0, 11, 'hB0));
    table_q.push_back(mk(0, 0, 0, 0,      1, 6, 'h66,    0, 0,  6, 0,  1, 1, 0, 11, 'hB0));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  6, 0,  1, 1, 1, 6,  'h66));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  6, 0,  1, 0, 0, 6,  'h66));
    table_q.push_back(mk(0, 0, 0, 0,      1, 9, 'h99,    0, 0,  0, 0,  1, 0, 0, 6,  'h66));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       1, 9,  0, 0,  1, 0, 1, 9,  'h99));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  9, 0,  1, 1, 0, 9,  'h99));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       1, 9,  0, 0,  1, 1, 0, 9,  'h99));
    table_q.push_back(mk(0, 0, 0, 0,      1, 9, 'h9A,    0, 0,  0, 0,  1, 0, 0, 9,  'h99));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  0, 9,  1, 1, 1, 9,  'h9A));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  0, 9,  1, 0, 0, 9,  'h9A));
    table_q.push_back(mk(0, 0, 0, 0,      1, 4, 'h44,    0, 0,  0, 0,  1, 0, 0, 9,  'h9A));
    table_q.push_back(mk(0, 1, 0, 'hDEAD, 0, 0, 0,       0, 0,  0, 0,  1, 0, 1, 4,  'h44));
    table_q.push_back(mk(0, 1, 0, 'hBEEF, 1, 0, 'h55,    0, 0,  0, 0,  1, 0, 0, 4,  'h44));
    table_q.push_back(mk(0, 0, 0, 0,      0, 0, 0,       0, 0,  0, 0,  1, 0, 0, 4,  'h44));

    foreach (table_q[i]) run_cycle(table_q[i], 1'b0);
    $display("[TB] directed table done, %0d checks", checks);

    // Three queued entries with pending destinations, then a one-cycle reset mid-stream.
    run_cycle(mk(0, 1, 3, 'h01, 1, 12, 'hC1, 1, 12, 0, 0,   1, 0, 1, 3, 'h01), 1'b0);
    run_cycle(mk(0, 1, 3, 'h02, 1, 13, 'hC2, 1, 13, 0, 0,   1, 0, 1, 3, 'h02), 1'b0);
    run_cycle(mk(0, 1, 3, 'h03, 1, 14, 'hC3, 0, 0,  12, 0,  1, 1, 1, 3, 'h03), 1'b0);
    run_cycle(mk(1, 1, 3, 'h04, 0, 0,  0,    0, 0,  12, 13, 0, 1, 0, 0, 0),    1'b0);
    run_cycle(mk(0, 0, 0, 0,    0, 0,  0,    0, 0,  12, 13, 1, 0, 0, 0, 0),    1'b0);
    run_cycle(mk(0, 0, 0, 0,    0, 0,  0,    0, 0,  0, 0,   1, 0, 0, 0, 0),    1'b0);
    run_cycle(mk(0, 0, 0, 0,    0, 0,  0,    0, 0,  14, 0,  1, 0, 0, 0, 0),    1'b0);
    $display("[TB] reset sequence done, %0d checks", checks);

    run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    for (int n = 0; n < 3000; n++) begin
      v = mk(($urandom_range(0, 99) == 0) ? 1 : 0,
             ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 11), $urandom,
             ($urandom_range(0, 1) == 0) ? 1 : 0, $urandom_range(0, 11), $urandom,
             ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 11),
             $urandom_range(0, 11), $urandom_range(0, 11),
             0, 0, 0, 0, 0);
      run_cycle(v, 1'b1);
    end
    $display("[TB] random phase done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
Writer side of the register-file write port (WriteEnable/rd/data), sitting at the end of the writeback stage. Merges single-cycle ALU results with long-latency load/multi-cycle results. Long-latency results are buffered in a small FIFO and issued one write per cycle. A 32-entry pending scoreboard drives a stall to decode, so rs1/rs2 reads never see stale data from an outstanding long-latency destination.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of two, >=2)
XLEN, 32, data width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alu_valid  in  1  ALU result valid this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
lsu_valid  in  1  long-latency result offered
lsu_ready  out  1  FIFO can accept (handshake = lsu_valid && lsu_ready)
lsu_rd  in  5  long-latency destination
lsu_data  in  XLEN  long-latency result
issue_valid  in  1  long-latency op issued by decode this cycle
issue_rd  in  5  destination of issued long-latency op
rs1  in  5  decode source 1
rs2  in  5  decode source 2
stall  out  1  decode must hold
rf_we  out  1  to regfile WriteEnable
rf_rd  out  5  to regfile rd
rf_data  out  XLEN  to regfile data

Behaviour:
- rf_we, rf_rd and rf_data are registered and update on posedge clk. The regfile samples them on the following negedge.
- Reset values: rf_we=0, rf_rd=0, rf_data=0. FIFO is empty (count=0). All pending bits are 0.
- lsu_ready = !rst && (count < DEPTH), combinational.
- Reset mid-operation discards all FIFO entries and pending bits. No write is emitted on the cycle after rst.
- Per-cycle write select, in priority order:
  1. If alu_valid && alu_rd!=0: rf_we<=1, rf_rd<=alu_rd, rf_data<=alu_data. The FIFO does not pop.
  2. Else if count>0: pop the head. rf_we<=1, rf_rd<=head.rd, rf_data<=head.data.
  3. Else: rf_we<=0. rf_rd and rf_data hold their previous values.
- An ALU result with rd=0 is discarded and does not occupy the port, so the FIFO may pop that cycle.
- Latency: an ALU result appears on rf_* 1 posedge after it is presented. A long-latency result accepted at edge N appears at edge N+1 at the earliest, even when the FIFO was empty.
- FIFO push on lsu_valid && lsu_ready && lsu_rd!=0.
  - A handshake with lsu_rd=0 is accepted and discarded (no push).
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - There is no push when full. Because lsu_ready depends on the current count, a simultaneous pop does not allow a push.
- Scoreboard (pending[31:0]):
  - issue_valid && issue_rd!=0 && !stall sets pending[issue_rd].
  - A FIFO pop clears pending[head.rd].
  - Set and clear of the same register in the same cycle: set wins.
  - pending[0] is always 0.
- stall (combinational) = (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]) || (issue_valid && issue_rd!=0 && pending[issue_rd]). The last term is the WAW hold.
- Pending status clears at the pop edge. The register is written at the next negedge, so decode reading at a later edge sees the new value.
- Order: the FIFO is strictly in order. ALU results may overtake queued long-latency results. Freedom from WAR/WAW corruption is guaranteed by the scoreboard stall, not by this block reordering.
- rf_we is never asserted with rf_rd=0.

Test Plan:
- ALU only: rst 2 cycles, then alu_valid=1, rd=5, data=0x0000_00AA → next edge rf_we=1, rf_rd=5, rf_data=0xAA. Following idle cycle → rf_we=0.
- LSU through empty FIFO: lsu_valid=1, rd=7, data=0x1234 at edge N with no ALU → rf_we=1, rf_rd=7, rf_data=0x1234 at edge N+1. count returns to 0.
- ALU priority/backpressure:
  - Push 4 LSU results (rd 8..11) while alu_valid held high, rd=3 → lsu_ready=0 after the 4th push. FIFO does not drain.
  - Drop alu_valid → writes rd 8,9,10,11 on 4 consecutive edges. lsu_ready=1 after the first pop.
- Scoreboard stall:
  - issue_valid, issue_rd=6 → pending[6]=1. rs1=6 → stall=1. rs1=0 → stall=0.
  - LSU result rd=6 accepted and popped → stall=0 from the pop edge.
- Simultaneous set/clear and WAW:
  - Pop of rd=9 in the same cycle as issue rd=9 → pending[9] stays 1.
  - issue_rd=9 again while pending → stall=1 and no set.
- Reset mid-op: FIFO holding 3 entries with pending bits set, assert rst 1 cycle → rf_we=0, lsu_ready=0 during rst, count=0, stall=0, no queued writes emitted afterward.
